// File: rtl/stmm_sched.sv
`default_nettype none
// ============================================================================
// Module   : stmm_sched
// Purpose  : In-order command scheduler for a bank of StMM sub-units. Commands
//            (FETCH weights/params or EXEC) are queued in a FIFO and issued
//            from the head only. One shared fetcher is sequenced by a
//            two-state FSM (IDLE/WAIT); EXEC commands may issue to any loaded,
//            non-busy sub-unit while a fetch for another sub is outstanding.
//            An EXEC aimed at a sub that is neither loaded nor being fetched
//            is dropped and flagged with err_unloaded.
//
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            cmd_valid/cmd_ready command handshake (ready = FIFO not full)
//            cmd_op              0 = FETCH, 1 = EXEC
//            cmd_sub, cmd_addr   target sub-unit, SDRAM fetch address
//            fetch, fetch_addr   one-hot fetch start pulse, held address
//            fetch_done          shared fetcher completion pulse
//            exec, exec_done     per-sub exec start / completion pulses
//            sub_loaded          sub holds a completed fetch
//            sub_busy            sub is executing
//            idle                FIFO empty, fetcher idle, no sub busy
//            err_unloaded        one-cycle pulse when an EXEC is dropped
//            stall_cycles        saturating head-stall counter (optional)
//
// Config   : define STMM_SCHED_PERF_EN to add the stall_cycles output.
//
// Revision : 1.0 - initial release
// ============================================================================
module stmm_sched #(
  parameter int SUB_NUM   = 4,
  parameter int CMD_DEPTH = 8,
  parameter int ADDR_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [$clog2(SUB_NUM)-1:0] cmd_sub,
  input  logic [ADDR_W-1:0]          cmd_addr,
  output logic [SUB_NUM-1:0]         fetch,
  output logic [ADDR_W-1:0]          fetch_addr,
  input  logic                       fetch_done,
  output logic [SUB_NUM-1:0]         exec,
  input  logic [SUB_NUM-1:0]         exec_done,
  output logic [SUB_NUM-1:0]         sub_loaded,
  output logic [SUB_NUM-1:0]         sub_busy,
  output logic                       idle,
  output logic                       err_unloaded
`ifdef STMM_SCHED_PERF_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int c_SUB_W = $clog2(SUB_NUM);
  localparam int c_PTR_W = $clog2(CMD_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CMD_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  localparam logic c_OP_FETCH = 1'b0;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_WAIT = 1'b1;

  // --------------------------------------------------------------------------
  // Command FIFO storage. Entries are not reset: the count gates every read.
  // --------------------------------------------------------------------------
  logic                r_mem_op   [CMD_DEPTH];
  logic [c_SUB_W-1:0]  r_mem_sub  [CMD_DEPTH];
  logic [ADDR_W-1:0]   r_mem_addr [CMD_DEPTH];

  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic [c_SUB_W-1:0]  r_fetch_sub;

  logic [SUB_NUM-1:0]  r_fetch;
  logic [SUB_NUM-1:0]  r_exec;
  logic [ADDR_W-1:0]   r_fetch_addr;
  logic [SUB_NUM-1:0]  r_sub_loaded;
  logic [SUB_NUM-1:0]  r_sub_busy;
  logic                r_err_unloaded;

  logic                w_push;
  logic                w_pop;
  logic                w_head_valid;
  logic                w_head_op;
  logic [c_SUB_W-1:0]  w_head_sub;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [SUB_NUM-1:0]  w_head_onehot;
  logic                w_in_wait;
  logic                w_head_fetching;
  logic                w_fetch_issue;
  logic                w_exec_issue;
  logic                w_exec_drop;
  logic                w_fetch_done_ok;

  // Ready comes from the registered count only; a pop in the same cycle does
  // not free a slot for the incoming command.
  assign cmd_ready    = (r_count != c_CNT_FULL);
  assign w_push       = cmd_valid && cmd_ready;
  assign w_head_valid = (r_count != '0);
  assign w_head_op    = r_mem_op[r_rd_ptr];
  assign w_head_sub   = r_mem_sub[r_rd_ptr];
  assign w_head_addr  = r_mem_addr[r_rd_ptr];

  always_comb begin : p_head_onehot
    w_head_onehot = '0;
    for (int k = 0; k < SUB_NUM; k++) begin
      if (w_head_sub == c_SUB_W'(k)) begin
        w_head_onehot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin : p_fifo_mem
    if (w_push) begin
      r_mem_op[r_wr_ptr]   <= cmd_op;
      r_mem_sub[r_wr_ptr]  <= cmd_sub;
      r_mem_addr[r_wr_ptr] <= cmd_addr;
    end
  end

  // Pointers are exactly c_PTR_W wide, so they wrap modulo the (power of two)
  // depth on their own.
  always_ff @(posedge clk or negedge rst_n) begin : p_fifo_ctrl
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : p_fsm_state
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM: next state. fetch_done is only meaningful while waiting.
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm_next
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: if (w_fetch_issue) w_state_next = c_ST_WAIT;
      c_ST_WAIT: if (fetch_done)    w_state_next = c_ST_IDLE;
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch FSM outputs / head issue decision. Exactly one of fetch-issue,
  // exec-issue, exec-drop can fire per cycle since all are decided for the
  // single head entry.
  // --------------------------------------------------------------------------
  always_comb begin : p_fsm_out
    w_in_wait       = (r_state == c_ST_WAIT);
    w_head_fetching = w_in_wait && (r_fetch_sub == w_head_sub);
    w_fetch_done_ok = w_in_wait && fetch_done;
    w_fetch_issue   = 1'b0;
    w_exec_issue    = 1'b0;
    w_exec_drop     = 1'b0;
    if (w_head_valid) begin
      if (w_head_op == c_OP_FETCH) begin
        w_fetch_issue = !w_in_wait && !r_sub_busy[w_head_sub];
      end else if (r_sub_loaded[w_head_sub]) begin
        w_exec_issue = !r_sub_busy[w_head_sub];
      end else begin
        // Not loaded: wait if its fetch is in flight, otherwise discard.
        w_exec_drop = !w_head_fetching;
      end
    end
    w_pop = w_fetch_issue || w_exec_issue || w_exec_drop;
  end

  // --------------------------------------------------------------------------
  // Registered pulses and per-sub status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : p_status
    if (!rst_n) begin
      r_fetch        <= '0;
      r_exec         <= '0;
      r_fetch_addr   <= '0;
      r_fetch_sub    <= '0;
      r_sub_loaded   <= '0;
      r_sub_busy     <= '0;
      r_err_unloaded <= 1'b0;
    end else begin
      r_fetch        <= w_fetch_issue ? w_head_onehot : '0;
      r_exec         <= w_exec_issue  ? w_head_onehot : '0;
      r_err_unloaded <= w_exec_drop;
      if (w_fetch_issue) begin
        r_fetch_addr <= w_head_addr;
        r_fetch_sub  <= w_head_sub;
      end
      // Fetch issue (IDLE) and fetch completion (WAIT) never coincide.
      if (w_fetch_issue) begin
        r_sub_loaded[w_head_sub] <= 1'b0;
      end
      if (w_fetch_done_ok) begin
        r_sub_loaded[r_fetch_sub] <= 1'b1;
      end
      // Exec issue requires the sub to be non-busy, so a coincident exec_done
      // on that bit is a stray and is correctly overridden by the set.
      r_sub_busy <= (r_sub_busy & ~exec_done) |
                    (w_exec_issue ? w_head_onehot : '0);
    end
  end

`ifdef STMM_SCHED_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin : p_perf
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_head_valid && !w_pop && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign fetch        = r_fetch;
  assign exec         = r_exec;
  assign fetch_addr   = r_fetch_addr;
  assign sub_loaded   = r_sub_loaded;
  assign sub_busy     = r_sub_busy;
  assign err_unloaded = r_err_unloaded;
  assign idle         = !w_head_valid && !w_in_wait && (r_sub_busy == '0);

endmodule
`default_nettype wire
